// File: rtl/cu_if.sv
// rtl/cu_if.sv - control/status bundle between the exponentiation datapath and its control unit
//
// Purpose: groups the datapath status inputs and the control outputs of cu
// so the datapath (or a bench) connects with a single port.
// Signals:
//   start    - request to begin an operation (datapath/host -> cu)
//   equals   - iteration counter at terminal value (datapath -> cu)
//   regBk    - exponent bit currently under test in register B (datapath -> cu)
//   LoadA    - load enable, register A (cu -> datapath)
//   LoadB    - parallel-load enable, register B (cu -> datapath)
//   ShiftB   - shift enable, register B (cu -> datapath)
//   LoadCoun - load enable, iteration counter (cu -> datapath)
//   S_Coun   - counter input select: 0 = initial value, 1 = counter - 1
//   LoadC    - load enable, result register C (cu -> datapath)
//   S_C      - C input select: 00 = 1, 01 = C*C, 10 = C*A, 11 = unused
// Modports:
//   master - the datapath side: drives status, receives controls
//   slave  - the control unit side: receives status, drives controls

interface cu_if;
  logic       start;
  logic       equals;
  logic       regBk;
  logic       LoadA;
  logic       LoadB;
  logic       ShiftB;
  logic       LoadCoun;
  logic       S_Coun;
  logic       LoadC;
  logic [1:0] S_C;

  modport master (
    output start, equals, regBk,
    input  LoadA, LoadB, ShiftB, LoadCoun, S_Coun, LoadC, S_C
  );

  modport slave (
    input  start, equals, regBk,
    output LoadA, LoadB, ShiftB, LoadCoun, S_Coun, LoadC, S_C
  );
endinterface

// File: rtl/cu.sv
// rtl/cu.sv - Moore control unit sequencing square-and-multiply exponentiation
//
// Purpose: walks the exponent bits held in register B. Each iteration squares
// C, shifts B and decrements the counter, and multiplies C by A when the bit
// under test was 1. The operation ends when the datapath reports the counter
// has reached its terminal value.
// Ports:
//   clk - clock, all state changes on its rising edge
//   rst - asynchronous active-high reset, forces INIT immediately
//   bus - cu_if.slave: start/equals/regBk in, load/shift/select controls out

module cu (
  input logic  clk,
  input logic  rst,
  cu_if.slave  bus
);

  // Three-bit encoding; the three unused codes fall back to INIT.
  typedef enum logic [2:0] {
    S1_INIT   = 3'd0,
    S2_CHECK  = 3'd1,
    S3_SQUARE = 3'd2,
    S4_TEST   = 3'd3,
    S5_MULT   = 3'd4
  } state_t;

  state_t state;
  state_t stateNext;

  logic       loadA;
  logic       loadB;
  logic       shiftB;
  logic       loadCoun;
  logic       sCoun;
  logic       loadC;
  logic [1:0] sC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S1_INIT;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state: each input is only looked at in the one state that uses it.
  always_comb begin
    stateNext = S1_INIT;
    case (state)
      S1_INIT:   stateNext = bus.start  ? S2_CHECK : S1_INIT;
      S2_CHECK:  stateNext = bus.equals ? S1_INIT  : S3_SQUARE;
      S3_SQUARE: stateNext = S4_TEST;
      // regBk is the pre-shift bit: B shifts on this same edge.
      S4_TEST:   stateNext = bus.regBk  ? S5_MULT  : S2_CHECK;
      S5_MULT:   stateNext = S2_CHECK;
      default:   stateNext = S1_INIT;
    endcase
  end

  // Outputs decode the state alone, so reset reaches them without a clock.
  always_comb begin
    loadA    = 1'b0;
    loadB    = 1'b0;
    shiftB   = 1'b0;
    loadCoun = 1'b0;
    sCoun    = 1'b0;
    loadC    = 1'b0;
    sC       = 2'b00;
    case (state)
      S1_INIT: begin
        // Re-initialise A, B, counter and C (C <= 1) on every pass.
        loadA    = 1'b1;
        loadB    = 1'b1;
        loadCoun = 1'b1;
        loadC    = 1'b1;
      end
      S3_SQUARE: begin
        loadC = 1'b1;
        sC    = 2'b01;
      end
      S4_TEST: begin
        shiftB   = 1'b1;
        loadCoun = 1'b1;
        sCoun    = 1'b1;
      end
      S5_MULT: begin
        loadC = 1'b1;
        sC    = 2'b10;
      end
      default: begin
      end
    endcase
  end

  assign bus.LoadA    = loadA;
  assign bus.LoadB    = loadB;
  assign bus.ShiftB   = shiftB;
  assign bus.LoadCoun = loadCoun;
  assign bus.S_Coun   = sCoun;
  assign bus.LoadC    = loadC;
  assign bus.S_C      = sC;

endmodule

// File: tb/tb_cu.sv
// tb/tb_cu.sv - self-checking bench for the exponentiation control unit

module tb_cu;
  logic clk = 1'b0;
  logic rst = 1'b1;

  cu_if bus ();

  cu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Output word order: {LoadA, LoadB, ShiftB, LoadCoun, S_Coun, LoadC, S_C[1:0]}
  localparam logic [7:0] O_INIT   = 8'b1101_0100;
  localparam logic [7:0] O_CHECK  = 8'b0000_0000;
  localparam logic [7:0] O_SQUARE = 8'b0000_0101;
  localparam logic [7:0] O_TEST   = 8'b0011_1000;
  localparam logic [7:0] O_MULT   = 8'b0000_0110;

  logic [7:0] dutOut;
  assign dutOut = {bus.LoadA, bus.LoadB, bus.ShiftB, bus.LoadCoun,
                   bus.S_Coun, bus.LoadC, bus.S_C};

  // Behavioural model: phase of the square-and-multiply algorithm.
  // 1 idle/init, 2 check for end, 3 square, 4 test bit + shift, 5 multiply.
  int mPhase = 1;

  function automatic logic [7:0] phaseOut(input int p);
    case (p)
      1:       return O_INIT;
      2:       return O_CHECK;
      3:       return O_SQUARE;
      4:       return O_TEST;
      default: return O_MULT;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase <= 1;
    end else begin
      case (mPhase)
        1:       mPhase <= bus.start  ? 2 : 1;
        2:       mPhase <= bus.equals ? 1 : 3;
        3:       mPhase <= 4;
        4:       mPhase <= bus.regBk  ? 5 : 2;
        default: mPhase <= 2;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (dutOut !== phaseOut(mPhase)) begin
      failures++;
      $display("FAIL model t=%0t phase=%0d got=%b expected=%b", $time, mPhase, dutOut, phaseOut(mPhase));
    end
  end

  task automatic expectLit(input string name, input logic [7:0] exp);
    checks++;
    if (dutOut !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, dutOut, exp);
    end
  endtask

  // Apply inputs at a falling edge, then advance one rising edge.
  task automatic cyc(input logic s, input logic e, input logic b);
    bus.start  = s;
    bus.equals = e;
    bus.regBk  = b;
    @(negedge clk);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.equals = 1'b0;
    bus.regBk  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    expectLit("reset_hold", O_INIT);
    @(negedge clk);
    rst = 1'b0;

    // idle
    cyc(0, 0, 0); expectLit("idle1", O_INIT);
    cyc(0, 1, 1); expectLit("idle2", O_INIT);
    cyc(0, 0, 0); expectLit("idle3", O_INIT);

    // zero-bit iteration: 3 cycles
    cyc(1, 0, 0); expectLit("zb_check", O_CHECK);
    cyc(0, 0, 0); expectLit("zb_square", O_SQUARE);
    cyc(0, 0, 0); expectLit("zb_test", O_TEST);
    cyc(0, 0, 0); expectLit("zb_back", O_CHECK);

    // one-bit iteration with foreign inputs toggled
    cyc(0, 0, 1); expectLit("ob_square", O_SQUARE);
    cyc(1, 1, 1); expectLit("ob_test", O_TEST);
    cyc(0, 0, 1); expectLit("ob_mult", O_MULT);
    cyc(1, 1, 0); expectLit("ob_back", O_CHECK);

    // done, wait, restart; then start held
    cyc(0, 1, 0); expectLit("done", O_INIT);
    cyc(0, 0, 0); expectLit("done_wait", O_INIT);
    cyc(1, 0, 0); expectLit("restart", O_CHECK);
    cyc(1, 1, 0); expectLit("held_init", O_INIT);
    cyc(1, 1, 0); expectLit("held_check", O_CHECK);
    cyc(1, 1, 0); expectLit("held_init2", O_INIT);

    // asynchronous reset during multiply
    cyc(1, 0, 0); expectLit("rr_check", O_CHECK);
    cyc(0, 0, 0); expectLit("rr_square", O_SQUARE);
    cyc(0, 0, 1); expectLit("rr_test", O_TEST);
    cyc(0, 0, 1); expectLit("rr_mult", O_MULT);
    #2 rst = 1'b1;
    #1 expectLit("rr_async", O_INIT);
    #1 rst = 1'b0;
    @(negedge clk);
    expectLit("rr_after_edge", O_INIT);
    cyc(1, 0, 0); expectLit("rr_resume", O_CHECK);

    // pseudo-random inputs, checked by the model
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
